// File: rtl/dma_master_mc_if.sv
// AXI bundle seen from the DMA master side.
// M2AXIin carries slave-to-master signals, M2AXIout master-to-slave.
interface inf_Master;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport M2AXIin (
    input arready,
    input rid, rdata, rresp, rlast, rvalid,
    input awready, wready,
    input bid, bresp, bvalid
  );

  modport M2AXIout (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready
  );
endinterface

// File: rtl/dma_master_mc.sv
// Multi-channel round-robin AXI DMA copy engine with 4 KB burst split.
// Define DMA_ERR_ABORT_EN to end a transfer after the first failing burst.
`ifndef AXI_DMA_ID
`define AXI_DMA_ID 4'd2
`endif
`ifndef AXI_SIZE_WORD
`define AXI_SIZE_WORD 3'b010
`endif
`ifndef AXI_BURST_INC
`define AXI_BURST_INC 2'b01
`endif
`ifndef AXI_STRB_WORD
`define AXI_STRB_WORD 4'hF
`endif

module dma_master_mc #(
  parameter int CH_NUM     = 2,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  inf_Master.M2AXIin           m2axi_i,
  inf_Master.M2AXIout          m2axi_o,
  input  logic [CH_NUM-1:0]    dma_en_i,
  input  logic [CH_NUM*32-1:0] src_addr_i,
  input  logic [CH_NUM*32-1:0] dst_addr_i,
  input  logic [CH_NUM*32-1:0] data_qty_i,
  output logic [CH_NUM-1:0]    dma_fin_o,
  output logic [CH_NUM-1:0]    dma_err_o,
  output logic                 busy_o
);
  localparam int CW  = $clog2(MAX_BURST) + 1;
  localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int FAW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, AR_CH, AW_CH, DATA, B_CH, FIN
  } state_t;

  state_t            state, state_nx;
  logic [31:0]       src_c [CH_NUM];
  logic [31:0]       dst_c [CH_NUM];
  logic [31:0]       qty_c [CH_NUM];
  logic [CH_NUM-1:0] pend, en_ok;
  logic [CHW-1:0]    ch, last, pick;
  logic              pick_v;
  logic [31:0]       src_r, dst_r, rem_r;
  logic [31:0]       rem_nx, step, lim;
  logic [31:0]       src_room, dst_room;
  logic [CW-1:0]     len_r, rd_cnt, wr_cnt;
  logic              err_r, abort;
  logic [31:0]       fifo [FIFO_DEPTH];
  logic [FAW:0]      wp, rp;
  logic              full, empty;
  logic              rd_ok, wv, push, pop;
  logic              last_beat, b_hs;
  logic              unused;

  assign full  = (wp[FAW] != rp[FAW]) &&
                 (wp[FAW-1:0] == rp[FAW-1:0]);
  assign empty = (wp == rp);

  assign rd_ok = (state == AW_CH || state == DATA) &&
                 !full && (rd_cnt != len_r);
  assign wv    = (state == DATA) && !empty;
  assign push  = rd_ok && m2axi_i.rvalid;
  assign pop   = wv && m2axi_i.wready;
  assign b_hs  = (state == B_CH) && m2axi_i.bvalid;

  assign last_beat = (wr_cnt == len_r - 1'b1);
  assign step      = 32'(len_r) << 2;
  assign rem_nx    = rem_r - 32'(len_r);

  assign src_room = 32'((13'h1000 - {1'b0, src_r[11:0]}) >> 2);
  assign dst_room = 32'((13'h1000 - {1'b0, dst_r[11:0]}) >> 2);

`ifdef DMA_ERR_ABORT_EN
  assign abort = err_r || (m2axi_i.bresp != 2'b00);
`else
  assign abort = 1'b0;
`endif

  assign unused = ^{m2axi_i.rid, m2axi_i.rlast,
                    m2axi_i.bid, lim[31:CW]};

  assign m2axi_o.arid    = `AXI_DMA_ID;
  assign m2axi_o.araddr  = src_r;
  assign m2axi_o.arlen   = 8'(len_r - 1'b1);
  assign m2axi_o.arsize  = `AXI_SIZE_WORD;
  assign m2axi_o.arburst = `AXI_BURST_INC;
  assign m2axi_o.awid    = `AXI_DMA_ID;
  assign m2axi_o.awaddr  = dst_r;
  assign m2axi_o.awlen   = 8'(len_r - 1'b1);
  assign m2axi_o.awsize  = `AXI_SIZE_WORD;
  assign m2axi_o.awburst = `AXI_BURST_INC;
  assign m2axi_o.wdata   = fifo[rp[FAW-1:0]];
  assign m2axi_o.wstrb   = `AXI_STRB_WORD;
  assign m2axi_o.wlast   = last_beat;

  // Round-robin pick: first pending channel after the last one served.
  always_comb begin
    pick   = '0;
    pick_v = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (!pick_v && pend[(int'(last) + 1 + i) % CH_NUM]) begin
        pick   = CHW'((int'(last) + 1 + i) % CH_NUM);
        pick_v = 1'b1;
      end
    end
  end

  // Enables for the channel in flight (or being picked) are dropped.
  always_comb begin
    en_ok = dma_en_i;
    for (int c = 0; c < CH_NUM; c++) begin
      if (CHW'(c) == ch && state != IDLE && state != FIN)
        en_ok[c] = 1'b0;
      if (CHW'(c) == pick && pick_v && state == IDLE)
        en_ok[c] = 1'b0;
    end
  end

  // Per-channel request contexts and pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        src_c[c] <= '0;
        dst_c[c] <= '0;
        qty_c[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (en_ok[c]) begin
          pend[c]  <= 1'b1;
          src_c[c] <= src_addr_i[c*32 +: 32];
          dst_c[c] <= dst_addr_i[c*32 +: 32];
          qty_c[c] <= data_qty_i[c*32 +: 32];
        end else if (state == IDLE && pick_v &&
                     pick == CHW'(c)) begin
          pend[c] <= 1'b0;
        end
      end
    end
  end

  // Burst length: remaining words capped by MAX_BURST and both pages.
  always_comb begin
    lim = rem_r;
    if (lim > 32'(MAX_BURST)) lim = 32'(MAX_BURST);
    if (lim > src_room) lim = src_room;
    if (lim > dst_room) lim = dst_room;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx         = state;
    m2axi_o.arvalid  = 1'b0;
    m2axi_o.awvalid  = 1'b0;
    m2axi_o.rready   = rd_ok;
    m2axi_o.wvalid   = wv;
    m2axi_o.bready   = 1'b0;
    dma_fin_o        = '0;
    dma_err_o        = '0;
    busy_o           = (state != IDLE);
    unique case (state)
      IDLE:  if (pick_v) state_nx = LOAD;
      LOAD:  state_nx = (rem_r == 32'd0) ? FIN : AR_CH;
      AR_CH: begin
        m2axi_o.arvalid = 1'b1;
        if (m2axi_i.arready) state_nx = AW_CH;
      end
      AW_CH: begin
        m2axi_o.awvalid = 1'b1;
        if (m2axi_i.awready) state_nx = DATA;
      end
      DATA:  if (pop && last_beat) state_nx = B_CH;
      B_CH: begin
        m2axi_o.bready = 1'b1;
        if (m2axi_i.bvalid)
          state_nx = (rem_nx != 32'd0 && !abort) ? LOAD : FIN;
      end
      FIN: begin
        dma_fin_o[ch] = 1'b1;
        dma_err_o[ch] = err_r;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read-to-write buffer storage.
  always_ff @(posedge clk) begin
    if (push) fifo[wp[FAW-1:0]] <= m2axi_i.rdata;
  end

  // State, working registers, counters and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ch     <= '0;
      last   <= CHW'(CH_NUM - 1);
      src_r  <= '0;
      dst_r  <= '0;
      rem_r  <= '0;
      len_r  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      err_r  <= 1'b0;
      wp     <= '0;
      rp     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_v) begin
        ch    <= pick;
        src_r <= src_c[pick];
        dst_r <= dst_c[pick];
        rem_r <= qty_c[pick];
        err_r <= 1'b0;
      end
      if (state == LOAD) begin
        len_r  <= lim[CW-1:0];
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      if (push) begin
        wp     <= wp + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
        if (m2axi_i.rresp != 2'b00) err_r <= 1'b1;
      end
      if (pop) begin
        rp     <= rp + 1'b1;
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (b_hs) begin
        rem_r <= rem_nx;
        src_r <= src_r + step;
        dst_r <= dst_r + step;
        if (m2axi_i.bresp != 2'b00) err_r <= 1'b1;
      end
      if (state == FIN) last <= ch;
    end
  end
endmodule
